// File: rtl/task_12_out_if.sv
// AXI-Stream output bundle of the task_12 output stage.
// Member names match the stage's external signal names so the frame
// boundary (o_tlast) and handshake (o_tvalid/i_tready) read the same everywhere.
interface task_12_out_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] o_tdata;
    logic                  o_tvalid;
    logic                  i_tready;
    logic                  o_tlast;

    modport master (
        output o_tdata,
        output o_tvalid,
        output o_tlast,
        input  i_tready
    );

    modport slave (
        input  o_tdata,
        input  o_tvalid,
        input  o_tlast,
        output i_tready
    );
endinterface

// File: rtl/task_12_out.sv
// task_12 output stage: collects one frame of NUM_WORDS words from the
// strobe-only input stage, replays it as an AXI-Stream master, then pulses
// o_output_last so the input stage fetches the next frame.
module task_12_out #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_WORDS  = 243
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_enb,
    task_12_out_if.master         axi,
    output logic                  o_output_last,
    output logic                  o_busy,
    output logic                  o_overflow
);
    localparam int CNT_WIDTH  = $clog2(NUM_WORDS + 1);
    localparam int ADDR_WIDTH = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(NUM_WORDS - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        s_COLLECT = 2'd0,
        s_DRAIN   = 2'd1,
        s_DONE    = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  wr_cnt_q, wr_cnt_d;
    logic [CNT_WIDTH-1:0]  rd_cnt_q, rd_cnt_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic                  tvalid_q, tvalid_d;
    logic                  tlast_q, tlast_d;
    logic                  output_last_q, output_last_d;
    logic                  busy_q, busy_d;
    logic                  overflow_q, overflow_d;

    logic                  mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_waddr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_d;
    logic [CNT_WIDTH-1:0]  rd_inc_s;

    logic [DATA_WIDTH-1:0] mem_q [NUM_WORDS];

    // Frame buffer write port; contents are not reset, counters define validity.
    always_ff @(posedge i_clk) begin
        if (mem_we_d) begin
            mem_q[mem_waddr_d] <= mem_wdata_d;
        end
    end

    // Next-state, counters and registered AXI outputs. The next word is
    // pre-fetched into tdata_d on each handshake so o_tdata stays a flop.
    always_comb begin
        state_d       = state_q;
        wr_cnt_d      = wr_cnt_q;
        rd_cnt_d      = rd_cnt_q;
        tdata_d       = tdata_q;
        tvalid_d      = tvalid_q;
        tlast_d       = tlast_q;
        output_last_d = 1'b0;
        busy_d        = busy_q;
        overflow_d    = overflow_q;
        mem_we_d      = 1'b0;
        mem_waddr_d   = wr_cnt_q[ADDR_WIDTH-1:0];
        mem_wdata_d   = i_data;
        rd_inc_s      = rd_cnt_q + CNT_ONE;

        case (state_q)
            s_COLLECT: begin
                if (i_enb) begin
                    mem_we_d = 1'b1;
                    busy_d   = 1'b1;
                    if (wr_cnt_q == LAST_IDX) begin
                        // Word 0 is already stored (frame >= 2 words), so it can be presented now.
                        state_d  = s_DRAIN;
                        wr_cnt_d = CNT_ZERO;
                        rd_cnt_d = CNT_ZERO;
                        tvalid_d = 1'b1;
                        tdata_d  = mem_q[0];
                        tlast_d  = 1'b0;
                    end else begin
                        wr_cnt_d = wr_cnt_q + CNT_ONE;
                    end
                end else begin
                    mem_we_d = 1'b0;
                end
            end
            s_DRAIN: begin
                if (i_enb) begin
                    overflow_d = 1'b1;
                end else begin
                    overflow_d = overflow_q;
                end
                if (tvalid_q && axi.i_tready) begin
                    if (rd_cnt_q == LAST_IDX) begin
                        state_d       = s_DONE;
                        rd_cnt_d      = CNT_ZERO;
                        tvalid_d      = 1'b0;
                        tlast_d       = 1'b0;
                        output_last_d = 1'b1;
                    end else begin
                        rd_cnt_d = rd_inc_s;
                        tdata_d  = mem_q[rd_inc_s[ADDR_WIDTH-1:0]];
                        tlast_d  = (rd_inc_s == LAST_IDX);
                    end
                end else begin
                    rd_cnt_d = rd_cnt_q;
                end
            end
            s_DONE: begin
                if (i_enb) begin
                    overflow_d = 1'b1;
                end else begin
                    overflow_d = overflow_q;
                end
                busy_d  = 1'b0;
                state_d = s_COLLECT;
            end
            default: begin
                state_d  = s_COLLECT;
                wr_cnt_d = CNT_ZERO;
                rd_cnt_d = CNT_ZERO;
                tvalid_d = 1'b0;
                tlast_d  = 1'b0;
                busy_d   = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= s_COLLECT;
            wr_cnt_q      <= CNT_ZERO;
            rd_cnt_q      <= CNT_ZERO;
            tdata_q       <= {DATA_WIDTH{1'b0}};
            tvalid_q      <= 1'b0;
            tlast_q       <= 1'b0;
            output_last_q <= 1'b0;
            busy_q        <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_cnt_q      <= wr_cnt_d;
            rd_cnt_q      <= rd_cnt_d;
            tdata_q       <= tdata_d;
            tvalid_q      <= tvalid_d;
            tlast_q       <= tlast_d;
            output_last_q <= output_last_d;
            busy_q        <= busy_d;
            overflow_q    <= overflow_d;
        end
    end

    assign axi.o_tdata    = tdata_q;
    assign axi.o_tvalid   = tvalid_q;
    assign axi.o_tlast    = tlast_q;
    assign o_output_last  = output_last_q;
    assign o_busy         = busy_q;
    assign o_overflow     = overflow_q;
endmodule

// File: tb/tb_task_12_out.sv
// Directed bench for task_12_out: a 4-word instance for handshake/boundary
// cases and a default 243-word instance streamed with random backpressure.
module tb_task_12_out;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] d4 = 8'h00;
    logic       e4 = 1'b0;
    logic [7:0] d243 = 8'h00;
    logic       e243 = 1'b0;
    logic       ol4, busy4, ovf4;
    logic       ol243, busy243, ovf243;
    int         total = 0;
    int         passed = 0;
    int         failed = 0;

    task_12_out_if #(.DATA_WIDTH(8)) a4 ();
    task_12_out_if #(.DATA_WIDTH(8)) a243 ();

    task_12_out #(.DATA_WIDTH(8), .NUM_WORDS(4)) dut4 (
        .i_clk(clk), .i_rst(rst), .i_data(d4), .i_enb(e4), .axi(a4),
        .o_output_last(ol4), .o_busy(busy4), .o_overflow(ovf4)
    );

    task_12_out #(.DATA_WIDTH(8)) dut243 (
        .i_clk(clk), .i_rst(rst), .i_data(d243), .i_enb(e243), .axi(a243),
        .o_output_last(ol243), .o_busy(busy243), .o_overflow(ovf243)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Writes four bytes back-to-back into the 4-word instance.
    task automatic write4(input string tag, input logic [31:0] frame);
        for (int i = 0; i < 4; i++) begin
            d4 = frame[31-8*i -: 8];
            e4 = 1'b1;
            step();
            chk({tag, "_wr_tvalid"}, 32'(a4.o_tvalid), (i == 3) ? 32'd1 : 32'd0);
            chk({tag, "_wr_busy"}, 32'(busy4), 32'd1);
        end
        e4 = 1'b0;
        chk({tag, "_first_tdata"}, 32'(a4.o_tdata), 32'(frame[31:24]));
    endtask

    // Drains the 4-word instance; mode 0 = ready always, mode 1 = ready 1,0,0 repeating.
    task automatic drain4(input string tag, input logic [31:0] frame, input int mode);
        int         hs = 0;
        int         pulses = 0;
        int         last_cyc = -1;
        logic       pv = 1'b0;
        logic       pr = 1'b0;
        logic [7:0] pd = 8'h00;
        logic       rdy;
        for (int c = 0; c < 40; c++) begin
            rdy = (mode == 0) ? 1'b1 : ((c % 3) == 0);
            a4.i_tready = rdy;
            if (ol4) begin
                pulses++;
                last_cyc = c;
            end
            if (pv && !pr) begin
                chk({tag, "_stall_tvalid"}, 32'(a4.o_tvalid), 32'd1);
                chk({tag, "_stall_tdata"}, 32'(a4.o_tdata), 32'(pd));
            end
            if (a4.o_tvalid && rdy) begin
                if (hs < 4) begin
                    chk({tag, "_beat_tdata"}, 32'(a4.o_tdata), 32'(frame[31-8*hs -: 8]));
                    chk({tag, "_beat_tlast"}, 32'(a4.o_tlast), (hs == 3) ? 32'd1 : 32'd0);
                end
                hs++;
            end
            pv = a4.o_tvalid;
            pr = rdy;
            pd = a4.o_tdata;
            step();
        end
        a4.i_tready = 1'b0;
        chk({tag, "_handshakes"}, 32'(hs), 32'd4);
        chk({tag, "_output_last_pulses"}, 32'(pulses), 32'd1);
        if (mode == 0) begin
            chk({tag, "_output_last_cycle"}, 32'(last_cyc), 32'd4);
        end
    endtask

    initial begin
        logic [6:0] gap_pat;
        int         w;
        a4.i_tready = 1'b0;
        a243.i_tready = 1'b0;

        // Reset state
        rst = 1'b1;
        step();
        step();
        chk("rst_tvalid", 32'(a4.o_tvalid), 32'd0);
        chk("rst_tlast", 32'(a4.o_tlast), 32'd0);
        chk("rst_tdata", 32'(a4.o_tdata), 32'd0);
        chk("rst_output_last", 32'(ol4), 32'd0);
        chk("rst_busy", 32'(busy4), 32'd0);
        chk("rst_overflow", 32'(ovf4), 32'd0);
        chk("rst243_tvalid", 32'(a243.o_tvalid), 32'd0);
        rst = 1'b0;
        step();

        // Back-to-back frame, sink always ready
        write4("s1", 32'h11223344);
        drain4("s1", 32'h11223344, 0);
        chk("s1_idle_busy", 32'(busy4), 32'd0);
        chk("s1_idle_tvalid", 32'(a4.o_tvalid), 32'd0);

        // Same frame with ready toggling 1,0,0
        write4("s2", 32'h11223344);
        drain4("s2", 32'h11223344, 1);
        chk("s2_overflow_clear", 32'(ovf4), 32'd0);

        // Gapped input: tvalid only after the fourth write
        gap_pat = 7'b1010011;
        w = 0;
        for (int i = 0; i < 7; i++) begin
            e4 = gap_pat[6-i];
            d4 = 8'h51 + 8'(w);
            if (gap_pat[6-i]) begin
                w++;
            end
            step();
            chk("s3_gap_tvalid", 32'(a4.o_tvalid), (i == 6) ? 32'd1 : 32'd0);
        end
        e4 = 1'b0;
        chk("s3_first_tdata", 32'(a4.o_tdata), 32'h51);

        // Word strobed during drain is dropped and flags overflow
        d4 = 8'hFF;
        e4 = 1'b1;
        step();
        e4 = 1'b0;
        chk("s4_overflow_set", 32'(ovf4), 32'd1);
        chk("s4_tdata_held", 32'(a4.o_tdata), 32'h51);
        drain4("s4", 32'h51525354, 0);
        chk("s4_overflow_sticky", 32'(ovf4), 32'd1);

        // Reset with a half-written frame
        d4 = 8'hEE;
        e4 = 1'b1;
        step();
        d4 = 8'hEF;
        step();
        e4 = 1'b0;
        rst = 1'b1;
        step();
        chk("s5_rst_tvalid", 32'(a4.o_tvalid), 32'd0);
        chk("s5_rst_tdata", 32'(a4.o_tdata), 32'd0);
        chk("s5_rst_tlast", 32'(a4.o_tlast), 32'd0);
        chk("s5_rst_output_last", 32'(ol4), 32'd0);
        chk("s5_rst_busy", 32'(busy4), 32'd0);
        chk("s5_rst_overflow", 32'(ovf4), 32'd0);
        rst = 1'b0;
        step();
        write4("s5", 32'hA0A1A2A3);
        drain4("s5", 32'hA0A1A2A3, 0);

        // Full-size frames with random backpressure
        for (int f = 0; f < 2; f++) begin
            int         hs;
            int         pulses;
            int         bad;
            logic       pv;
            logic       pr;
            logic [7:0] pd;
            logic       rdy;
            for (int i = 0; i < 243; i++) begin
                d243 = 8'(i);
                e243 = 1'b1;
                step();
            end
            e243 = 1'b0;
            chk("s6_tvalid_rise", 32'(a243.o_tvalid), 32'd1);
            chk("s6_first_tdata", 32'(a243.o_tdata), 32'd0);
            hs = 0;
            pulses = 0;
            bad = 0;
            pv = 1'b0;
            pr = 1'b0;
            pd = 8'h00;
            for (int c = 0; c < 2000 && pulses == 0; c++) begin
                rdy = 1'($urandom_range(0, 1));
                a243.i_tready = rdy;
                if (ol243) begin
                    pulses++;
                end
                if (pv && !pr && (a243.o_tdata !== pd || a243.o_tvalid !== 1'b1)) begin
                    bad++;
                end
                if (a243.o_tvalid && rdy) begin
                    if (hs < 243) begin
                        chk("s6_beat_tdata", 32'(a243.o_tdata), 32'(hs));
                        chk("s6_beat_tlast", 32'(a243.o_tlast), (hs == 242) ? 32'd1 : 32'd0);
                    end
                    hs++;
                end
                pv = a243.o_tvalid;
                pr = rdy;
                pd = a243.o_tdata;
                step();
            end
            a243.i_tready = 1'b0;
            chk("s6_handshakes", 32'(hs), 32'd243);
            chk("s6_output_last_seen", 32'(pulses), 32'd1);
            chk("s6_stall_stability_errors", 32'(bad), 32'd0);
            step();
            chk("s6_idle_busy", 32'(busy243), 32'd0);
            chk("s6_overflow", 32'(ovf243), 32'd0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
